flags_branch_unit: RTL and testbench
====================================

Name: flags_branch_unit

Overview:
- Consumes the ALU zero/negative/carry/overflow outputs (Z from the 64-bit zero detector) and holds the architectural NZCV register.
- Evaluates branch decisions for B, B.cond, CBZ and CBNZ in the decode stage.
- Sits between the EX-stage ALU and the IF-stage PC-redirect logic of the 5-stage pipeline.
- Provides same-cycle flag bypass, so a B.cond directly behind a flag-setting instruction resolves without a stall.

Parameters:
- FLAG_BYPASS, 1: 1 = branch evaluation uses EX-stage flags when a flag-setting instruction is in EX; 0 = always uses the registered NZCV.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  pipeline hold; blocks all register updates
- flush  input  1  squashes the ID instruction and the pending redirect
- ex_valid  input  1  EX stage holds a live instruction
- ex_setflags  input  1  EX instruction writes flags (ADDS/SUBS)
- ex_z  input  1  ALU zero flag
- ex_n  input  1  ALU negative flag
- ex_c  input  1  ALU carry flag
- ex_v  input  1  ALU overflow flag
- id_valid  input  1  ID stage holds a live instruction
- id_brtype  input  3  0 = none, 1 = B, 2 = B.cond, 3 = CBZ, 4 = CBNZ, 5–7 = none
- id_cond  input  4  ARM condition code for B.cond
- id_rt_zero  input  1  zero-detect of the CBZ/CBNZ test register (already forwarded)
- nzcv  output  4  architectural flags {N,Z,C,V}
- br_taken  output  1  combinational ID-stage decision
- redirect  output  1  registered br_taken; drives IF PC select
- flag_updates  output  8  count of flag writes, wraps at 255 (debug)

Behaviour:
- Reset: nzcv = 4'b0000, redirect = 0, flag_updates = 0. Takes effect asynchronously, including mid-operation.
- Flag write: at the clock edge when ex_valid & ex_setflags & ~stall, nzcv <= {ex_n, ex_z, ex_c, ex_v} and flag_updates increments (255 -> 0). Otherwise both hold. flush does not block flag writes, because EX is older than ID.
- Effective flags F:
  - F = {ex_n, ex_z, ex_c, ex_v} if FLAG_BYPASS & ex_valid & ex_setflags.
  - Otherwise F = nzcv.
- Condition evaluation (id_cond, on F):
  - 0 EQ: Z; 1 NE: ~Z; 2 HS: C; 3 LO: ~C; 4 MI: N; 5 PL: ~N; 6 VS: V; 7 VC: ~V.
  - 8 HI: C & ~Z; 9 LS: ~C | Z; 10 GE: N == V; 11 LT: N != V; 12 GT: ~Z & (N == V); 13 LE: Z | (N != V).
  - 14 AL and 15 NV: 1.
- br_taken: 0 unless id_valid & ~flush.
  - B: 1.
  - B.cond: cond result.
  - CBZ: id_rt_zero.
  - CBNZ: ~id_rt_zero.
  - Other types: 0.
  - CBZ/CBNZ never read the flags.
- redirect:
  - Next edge: redirect <= br_taken if ~stall & ~flush.
  - flush (checked first): redirect <= 0.
  - stall without flush: redirect holds.
  - Latency: one cycle from ID decision to redirect.
- Simultaneous events:
  - Flag write plus B.cond in the same cycle: the branch uses the bypassed EX flags; nzcv updates at the edge.
  - stall with a flag-setting instruction in EX: no nzcv write, and the bypass still applies to br_taken. redirect is frozen, so this has no observable effect.
- nzcv changes only at clock edges or on reset; there are no combinational paths from the ID inputs to nzcv.

Test Plan:
1. Reset: assert reset mid-cycle with nzcv = 4'b1010 -> nzcv = 0, redirect = 0, flag_updates = 0 immediately, without a clock edge.
2. Flag write: ex_valid = 1, ex_setflags = 1, {n,z,c,v} = 0100 -> after the edge, nzcv = 4'b0100 and flag_updates = 1; the same cycle with ex_setflags = 0 -> no change.
3. Bypass: nzcv = 0000, EX sets Z = 1, ID holds B.cond EQ -> br_taken = 1 in the same cycle and redirect = 1 next cycle. With FLAG_BYPASS = 0 -> br_taken = 0.
4. Signed conditions: nzcv = 1001 (N = 1, V = 1) -> GE = 1, LT = 0, GT = 1, LE = 0. nzcv = 1100 -> LE = 1, GT = 0.
5. CBZ/CBNZ: id_rt_zero = 1 -> CBZ taken, CBNZ not taken, regardless of nzcv (sweep all 16 values).
6. Controls:
   - stall with br_taken = 1 -> redirect holds its prior value and nzcv is unchanged.
   - flush -> br_taken = 0 and redirect = 0 next edge.
   - 256 flag writes -> flag_updates wraps to 0.

Source files
------------

// File: rtl/flags_branch_unit.sv
// flags_branch_unit
//   Holds the architectural NZCV register, fed from the EX-stage ALU flags.
//   Resolves B, B.cond, CBZ and CBNZ in the decode stage.
//   Registers the decision into the IF-stage PC-redirect select.
//   With FLAG_BYPASS set, a B.cond directly behind a flag-setting instruction
//   reads the EX-stage flags in the same cycle, so it does not stall.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   stall, flush        pipeline hold (blocks every register update) and ID squash
//   ex_valid/ex_setflags live EX instruction that writes flags
//   ex_z/ex_n/ex_c/ex_v ALU flag outputs
//   id_valid            live ID instruction
//   id_brtype           0/5-7 none, 1 B, 2 B.cond, 3 CBZ, 4 CBNZ
//   id_cond             condition code for B.cond
//   id_rt_zero          forwarded zero-detect of the CBZ/CBNZ register
//   nzcv                architectural flags {N,Z,C,V}
//   br_taken            combinational ID-stage decision
//   redirect            br_taken registered one cycle; drives IF PC select
//   flag_updates        wrapping count of flag writes (debug)
module flags_branch_unit #(
  parameter logic FLAG_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       ex_valid,
  input  logic       ex_setflags,
  input  logic       ex_z,
  input  logic       ex_n,
  input  logic       ex_c,
  input  logic       ex_v,
  input  logic       id_valid,
  input  logic [2:0] id_brtype,
  input  logic [3:0] id_cond,
  input  logic       id_rt_zero,
  output logic [3:0] nzcv,
  output logic       br_taken,
  output logic       redirect,
  output logic [7:0] flag_updates
);

  localparam logic [2:0] BR_B    = 3'd1;
  localparam logic [2:0] BR_COND = 3'd2;
  localparam logic [2:0] BR_CBZ  = 3'd3;
  localparam logic [2:0] BR_CBNZ = 3'd4;

  logic [3:0] nzcv_q, nzcv_d;
  logic       redirect_q, redirect_d;
  logic [7:0] flag_updates_q, flag_updates_d;

  logic       ex_flag_wr;
  logic [3:0] ex_flags;
  logic [3:0] eff_flags;
  logic       f_n, f_z, f_c, f_v;
  logic       cond_pass;
  logic       br_taken_c;

  assign ex_flags   = {ex_n, ex_z, ex_c, ex_v};
  assign ex_flag_wr = ex_valid & ex_setflags;

  // The bypass ignores stall on purpose: a stalled cycle freezes redirect, so
  // the bypassed decision is never captured and has no visible effect.
  assign eff_flags = (FLAG_BYPASS && ex_flag_wr) ? ex_flags : nzcv_q;
  assign {f_n, f_z, f_c, f_v} = eff_flags;

  always_comb begin
    cond_pass = 1'b1;
    case (id_cond)
      4'd0:    cond_pass = f_z;
      4'd1:    cond_pass = ~f_z;
      4'd2:    cond_pass = f_c;
      4'd3:    cond_pass = ~f_c;
      4'd4:    cond_pass = f_n;
      4'd5:    cond_pass = ~f_n;
      4'd6:    cond_pass = f_v;
      4'd7:    cond_pass = ~f_v;
      4'd8:    cond_pass = f_c & ~f_z;
      4'd9:    cond_pass = ~f_c | f_z;
      4'd10:   cond_pass = (f_n == f_v);
      4'd11:   cond_pass = (f_n != f_v);
      4'd12:   cond_pass = ~f_z & (f_n == f_v);
      4'd13:   cond_pass = f_z | (f_n != f_v);
      default: cond_pass = 1'b1;  // AL and NV both always pass
    endcase
  end

  always_comb begin
    br_taken_c = 1'b0;
    if (id_valid && !flush) begin
      case (id_brtype)
        BR_B:    br_taken_c = 1'b1;
        BR_COND: br_taken_c = cond_pass;
        BR_CBZ:  br_taken_c = id_rt_zero;
        BR_CBNZ: br_taken_c = ~id_rt_zero;
        default: br_taken_c = 1'b0;
      endcase
    end
  end

  // flush does not gate the flag write: the EX instruction is older than ID.
  always_comb begin
    nzcv_d         = nzcv_q;
    flag_updates_d = flag_updates_q;
    if (ex_flag_wr && !stall) begin
      nzcv_d         = ex_flags;
      flag_updates_d = flag_updates_q + 8'd1;
    end
  end

  always_comb begin
    redirect_d = redirect_q;
    if (flush)       redirect_d = 1'b0;
    else if (!stall) redirect_d = br_taken_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv_q         <= 4'b0000;
      redirect_q     <= 1'b0;
      flag_updates_q <= 8'd0;
    end else begin
      nzcv_q         <= nzcv_d;
      redirect_q     <= redirect_d;
      flag_updates_q <= flag_updates_d;
    end
  end

  assign nzcv         = nzcv_q;
  assign br_taken     = br_taken_c;
  assign redirect     = redirect_q;
  assign flag_updates = flag_updates_q;

endmodule

// File: tb/tb_flags_branch_unit.sv
// Bench for flags_branch_unit: two instances (bypass on / off) driven from the
// same inputs. A driver pushes the expected outputs of each cycle into a
// queue; a monitor pops and compares on every falling edge.
module tb_flags_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall, flush, ex_valid, ex_setflags, ex_z, ex_n, ex_c, ex_v;
  logic       id_valid, id_rt_zero;
  logic [2:0] id_brtype;
  logic [3:0] id_cond;

  logic [3:0] nzcv0, nzcv1;
  logic       br0, br1, red0, red1;
  logic [7:0] fu0, fu1;

  flags_branch_unit #(.FLAG_BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .ex_z(ex_z), .ex_n(ex_n), .ex_c(ex_c), .ex_v(ex_v),
    .id_valid(id_valid), .id_brtype(id_brtype), .id_cond(id_cond),
    .id_rt_zero(id_rt_zero),
    .nzcv(nzcv0), .br_taken(br0), .redirect(red0), .flag_updates(fu0)
  );

  flags_branch_unit #(.FLAG_BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .ex_z(ex_z), .ex_n(ex_n), .ex_c(ex_c), .ex_v(ex_v),
    .id_valid(id_valid), .id_brtype(id_brtype), .id_cond(id_cond),
    .id_rt_zero(id_rt_zero),
    .nzcv(nzcv1), .br_taken(br1), .redirect(red1), .flag_updates(fu1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    br0, br1, red0, red1, nzcv, fu;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  int m_nzcv = 0;
  int m_fu   = 0;
  int m_red0 = 0;
  int m_red1 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ARM ConditionHolds: cond[3:1] picks the test, cond[0] inverts it, except 1111.
  function automatic int cond_holds(input int cond, input int flags);
    int n, z, c, v, r;
    n = (flags >> 3) & 1; z = (flags >> 2) & 1; c = (flags >> 1) & 1; v = flags & 1;
    case (cond / 2)
      0: r = z;
      1: r = c;
      2: r = n;
      3: r = v;
      4: r = (c == 1 && z == 0) ? 1 : 0;
      5: r = (n == v) ? 1 : 0;
      6: r = (n == v && z == 0) ? 1 : 0;
      default: r = 1;
    endcase
    if ((cond % 2) == 1 && cond != 15) r = 1 - r;
    return r;
  endfunction

  function automatic int decide(input int idv, input int fl, input int bt,
                                input int cond, input int rtz, input int flags);
    if (idv == 0 || fl == 1) return 0;
    case (bt)
      1: return 1;
      2: return cond_holds(cond, flags);
      3: return rtz;
      4: return 1 - rtz;
      default: return 0;
    endcase
  endfunction

  // One cycle: apply inputs, record expected outputs for this cycle, advance model.
  task automatic step(input string tag, input int st, input int fl,
                      input int exv, input int exs, input int fl4,
                      input int idv, input int bt, input int cond, input int rtz);
    exp_t e;
    int   wr, fb, b0, b1;
    stall = st[0]; flush = fl[0]; ex_valid = exv[0]; ex_setflags = exs[0];
    {ex_n, ex_z, ex_c, ex_v} = fl4[3:0];
    id_valid = idv[0]; id_brtype = bt[2:0]; id_cond = cond[3:0]; id_rt_zero = rtz[0];
    wr = (exv == 1 && exs == 1) ? 1 : 0;
    fb = wr ? fl4 : m_nzcv;
    b0 = decide(idv, fl, bt, cond, rtz, fb);
    b1 = decide(idv, fl, bt, cond, rtz, m_nzcv);
    e.tag = tag; e.br0 = b0; e.br1 = b1; e.red0 = m_red0; e.red1 = m_red1;
    e.nzcv = m_nzcv; e.fu = m_fu;
    sb.push_back(e);
    if (wr == 1 && st == 0) begin
      m_nzcv = fl4;
      m_fu   = (m_fu + 1) % 256;
    end
    if (fl == 1) begin
      m_red0 = 0; m_red1 = 0;
    end else if (st == 0) begin
      m_red0 = b0; m_red1 = b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wflags(input string tag, input int f);
    step(tag, 0, 0, 1, 1, f, 0, 0, 0, 0);
  endtask

  task automatic bcond(input string tag, input int cond);
    step(tag, 0, 0, 0, 0, 0, 1, 2, cond, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".br_taken"},       int'(br0),  e.br0);
        chk({e.tag, ".br_taken_nobyp"}, int'(br1),  e.br1);
        chk({e.tag, ".redirect"},       int'(red0), e.red0);
        chk({e.tag, ".redirect_nobyp"}, int'(red1), e.red1);
        chk({e.tag, ".nzcv"},           int'(nzcv0), e.nzcv);
        chk({e.tag, ".flag_updates"},   int'(fu0),  e.fu);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    reset = 1'b1;
    stall = 0; flush = 0; ex_valid = 0; ex_setflags = 0;
    ex_z = 0; ex_n = 0; ex_c = 0; ex_v = 0;
    id_valid = 0; id_brtype = 0; id_cond = 0; id_rt_zero = 0;
    #3 reset = 1'b0;
    @(posedge clk); #1;

    idle("reset_state");

    // flag write, then a cycle with setflags low must not change anything
    wflags("fw_0100", 4'b0100);
    step("fw_nosetflags", 0, 0, 1, 0, 4'b1011, 0, 0, 0, 0);
    idle("fw_hold");

    // bypass: nzcv 0000, EX sets Z while ID holds B.cond EQ
    wflags("byp_clear", 4'b0000);
    step("byp_eq", 0, 0, 1, 1, 4'b0100, 1, 2, 0, 0);
    idle("byp_redirect");

    // signed conditions
    wflags("sgn_1001", 4'b1001);
    bcond("ge_1001", 10);
    bcond("lt_1001", 11);
    bcond("gt_1001", 12);
    bcond("le_1001", 13);
    wflags("sgn_1100", 4'b1100);
    bcond("le_1100", 13);
    bcond("gt_1100", 12);
    for (int c = 0; c < 16; c++) bcond("cond_sweep", c);

    // CBZ/CBNZ ignore flags, including bypassed EX flags
    for (int f = 0; f < 16; f++) begin
      wflags("cb_setup", f);
      step("cbz", 0, 0, 0, 0, 0, 1, 3, 0, 1);
      step("cbnz", 0, 0, 1, 1, 15 - f, 1, 4, 0, 1);
    end

    // stall with taken branch and flag write pending; then flush
    step("pre_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("stall_br", 1, 0, 1, 1, 4'b1111, 1, 1, 0, 0);
    step("stall_br2", 1, 0, 0, 0, 0, 1, 1, 0, 0);
    step("unstall_br", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step("flush_br", 0, 1, 1, 1, 4'b0010, 1, 1, 0, 0);
    step("flush_stall", 1, 1, 0, 0, 0, 1, 1, 0, 0);
    idle("after_flush");

    // wrap the debug counter
    for (int i = 0; i < 256; i++) wflags("wrap", i % 16);
    idle("wrap_done");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 1));
    end

    // asynchronous reset mid-cycle with nzcv = 1010
    wflags("pre_reset", 4'b1010);
    idle("pre_reset_chk");
    wait (sb.size() == 0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset.nzcv", int'(nzcv0), 0);
    chk("async_reset.redirect", int'(red0), 0);
    chk("async_reset.flag_updates", int'(fu0), 0);
    #1 reset = 1'b0;
    m_nzcv = 0; m_fu = 0; m_red0 = 0; m_red1 = 0;
    step("post_reset_br", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle("post_reset");

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
